// File: rtl/pgmap_stat_ctl.sv
// pgmap_stat_ctl: queues page-map accessed/modified updates and writes them back through a req/gnt slot.
// Define STAT_COALESCE_EN to merge an update into a queued entry for the same page.
module pgmap_stat_ctl #(
    parameter int PAGE_AW = 12,
    parameter int DEPTH   = 4
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               ref_valid,
    input  logic [PAGE_AW-1:0] ref_page,
    input  logic               ref_read,
    input  logic               p_fc0,
    input  logic               p_fc1,
    input  logic               p_back,
    input  logic               booten,
    input  logic               pm_acc_in,
    input  logic               pm_mod_in,
    output logic               ref_stall,
    output logic               pm_req,
    input  logic               pm_gnt,
    output logic               pm_we,
    output logic [PAGE_AW-1:0] pm_addr,
    output logic               pm_acc,
    output logic               pm_mod,
    output logic               busy
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, WR} state_t;
    state_t             state_q, state_d;
    logic [PAGE_AW-1:0] page_q [DEPTH];
    logic [DEPTH-1:0]   acc_q, mod_q, hit;
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PW:0]        cnt_q, cnt_d;
    logic               dis, need, new_mod, full, push, pop;

    assign dis       = (p_fc0 & p_fc1 & ~p_back) | (p_fc1 & p_back) | booten;
    assign need      = ref_valid & ~dis & (~pm_acc_in | (~ref_read & ~pm_mod_in));
    assign new_mod   = pm_mod_in | ~ref_read;
    assign full      = cnt_q == (PW+1)'(DEPTH);
    assign ref_stall = full;
    assign pop       = state_q == WR;
    assign push      = need & ~full & ~|hit;
    assign cnt_d     = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

`ifdef STAT_COALESCE_EN
    // A slot is live when it lies within cnt_q of the head; the head is frozen while being written.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++)
            hit[i] = need && page_q[i] == ref_page && {1'b0, PW'(i) - rd_ptr_q} < cnt_q &&
                     !(pop && PW'(i) == rd_ptr_q);
    end
`else
    assign hit = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cnt_q != '0 ? REQ : IDLE;
            REQ:     state_d = pm_gnt ? WR : REQ;
            WR:      state_d = cnt_d != '0 ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pm_req  = state_q == REQ;
    assign pm_we   = pop;
    assign pm_addr = pop ? page_q[rd_ptr_q] : '0;
    assign pm_acc  = pop & acc_q[rd_ptr_q];
    assign pm_mod  = pop & mod_q[rd_ptr_q];
    assign busy    = cnt_q != '0 || state_q != IDLE;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mod_q    <= '0;
            for (int i = 0; i < DEPTH; i++) page_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++)
                if (hit[i]) mod_q[i] <= mod_q[i] | new_mod;
            if (push) begin
                page_q[wr_ptr_q] <= ref_page;
                acc_q[wr_ptr_q]  <= 1'b1;
                mod_q[wr_ptr_q]  <= new_mod;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end
endmodule

// File: tb/tb_pgmap_stat_ctl.sv
// tb_pgmap_stat_ctl: directed and random references against a list-of-owed-writes model with a write monitor.
module tb_pgmap_stat_ctl;
    localparam int AW = 12;
    localparam int DEPTH = 4;

    logic CLK = 1'b0, RST_n = 1'b0;
    logic ref_valid = 1'b0, ref_read = 1'b0, p_fc0 = 1'b0, p_fc1 = 1'b0, p_back = 1'b0;
    logic booten = 1'b0, pm_acc_in = 1'b0, pm_mod_in = 1'b0, pm_gnt = 1'b0;
    logic [AW-1:0] ref_page = '0;
    logic ref_stall, pm_req, pm_we, pm_acc, pm_mod, busy;
    logic [AW-1:0] pm_addr;

    int errors = 0, checks = 0;
    typedef struct {logic [AW-1:0] page; logic mod;} upd_t;
    upd_t pend[$];
    bit pop_pend = 1'b0;
    bit gnt_rand = 1'b0;

    always #5 CLK = ~CLK;

    pgmap_stat_ctl #(.PAGE_AW(AW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_n(RST_n), .ref_valid(ref_valid), .ref_page(ref_page), .ref_read(ref_read),
        .p_fc0(p_fc0), .p_fc1(p_fc1), .p_back(p_back), .booten(booten),
        .pm_acc_in(pm_acc_in), .pm_mod_in(pm_mod_in), .ref_stall(ref_stall), .pm_req(pm_req),
        .pm_gnt(pm_gnt), .pm_we(pm_we), .pm_addr(pm_addr), .pm_acc(pm_acc), .pm_mod(pm_mod), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pend holds the writes still owed, oldest first, exactly as the spec's queue would.
    always @(posedge CLK) begin : model
        bit popping, dis, nm, merged;
        if (RST_n) begin
            popping  = pop_pend;
            pop_pend = 1'b0;
            dis      = (p_fc0 & p_fc1 & ~p_back) | (p_fc1 & p_back) | booten;
            nm       = pm_mod_in | ~ref_read;
            merged   = 1'b0;
            if (ref_valid && !dis && (!pm_acc_in || (!ref_read && !pm_mod_in))) begin
`ifdef STAT_COALESCE_EN
                for (int i = popping ? 1 : 0; i < pend.size(); i++)
                    if (pend[i].page == ref_page) begin
                        pend[i].mod = pend[i].mod | nm;
                        merged = 1'b1;
                    end
`endif
                if (!merged && pend.size() < DEPTH) pend.push_back('{ref_page, nm});
            end
            if (popping) void'(pend.pop_front());
        end
    end

    always @(negedge RST_n) begin
        pend.delete();
        pop_pend = 1'b0;
    end

    always @(negedge CLK) begin
        if (RST_n) begin
            chk("stall", 32'(ref_stall), 32'(pend.size() == DEPTH));
            chk("busy", 32'(busy), 32'(pend.size() != 0));
            if (pend.size() == 0) chk("req_idle", 32'(pm_req), 0);
            if (pm_we) begin
                if (pend.size() == 0) chk("spurious_we", 32'(pm_we), 0);
                else begin
                    chk("addr", 32'(pm_addr), 32'(pend[0].page));
                    chk("acc", 32'(pm_acc), 1);
                    chk("mod", 32'(pm_mod), 32'(pend[0].mod));
                    pop_pend = 1'b1;
                end
            end else chk("bus_zero", 32'({pm_addr, pm_acc, pm_mod}), 0);
        end
    end

    always @(posedge CLK) if (gnt_rand) begin
        #1 pm_gnt = $urandom_range(0, 99) < 60;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic present(input logic [AW-1:0] pg, input logic rd, f0, f1, bk, bt, ai, mi);
        ref_valid = 1'b1; ref_page = pg; ref_read = rd; p_fc0 = f0; p_fc1 = f1;
        p_back = bk; booten = bt; pm_acc_in = ai; pm_mod_in = mi;
    endtask

    task automatic wait_accept(input int bound);
        int n = 0;
        logic st;
        do begin
            st = ref_stall;
            tick();
            n++;
        end while (st && n < bound);
        chk("accept_timeout", 32'(st), 0);
        ref_valid = 1'b0;
    endtask

    task automatic send(input logic [AW-1:0] pg, input logic rd, f0, f1, bk, bt, ai, mi);
        present(pg, rd, f0, f1, bk, bt, ai, mi);
        wait_accept(50);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((pend.size() != 0 || busy) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(pend.size()), 0);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_outs", 32'({ref_stall, pm_req, pm_we, pm_acc, pm_mod, busy}), 0);
        chk("rst_addr", 32'(pm_addr), 0);
        RST_n = 1'b1;
        tick();

        pm_gnt = 1'b1;
        send(12'h012, 1, 1, 0, 0, 0, 0, 0);
        chk("lat_accept", 32'(pm_req), 0);
        tick(); chk("lat_req", 32'(pm_req), 1);
        tick(); chk("lat_we", 32'(pm_we), 1);
        tick(); chk("lat_done", 32'(busy), 0);

        send(12'h3A0, 0, 0, 0, 0, 0, 1, 0);
        drain(50);
        send(12'h3A0, 0, 0, 0, 0, 0, 1, 1);
        repeat (4) begin chk("no_req_stat_set", 32'(pm_req), 0); tick(); end

        send(12'h100, 1, 1, 1, 0, 0, 0, 0);
        send(12'h101, 1, 0, 1, 1, 0, 0, 0);
        send(12'h102, 0, 0, 0, 0, 1, 0, 0);
        repeat (4) begin chk("no_req_dis", 32'({pm_req, busy}), 0); tick(); end

        pm_gnt = 1'b0;
        for (int i = 0; i < 4; i++) send(AW'(12'h200 + i), 1, 0, 0, 0, 0, 0, 0);
        present(12'h204, 1, 0, 0, 0, 0, 0, 0);
        chk("stall_5th", 32'(ref_stall), 1);
        repeat (3) tick();
        chk("stall_held", 32'(ref_stall), 1);
        pm_gnt = 1'b1;
        wait_accept(50);
        drain(100);

        pm_gnt = 1'b0;
        send(12'h044, 1, 0, 0, 0, 0, 0, 0);
        send(12'h044, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        pm_gnt = 1'b1;
        drain(50);

        pm_gnt = 1'b0;
        for (int i = 0; i < 3; i++) send(AW'(12'h300 + i), 0, 0, 0, 0, 0, 0, 0);
        pm_gnt = 1'b1;
        n = 0;
        while (!pm_we && n < 20) begin tick(); n++; end
        chk("reach_wr", 32'(pm_we), 1);
        #1 RST_n = 1'b0;
        #1 chk("rst_mid_wr", 32'({pm_we, pm_req, busy, ref_stall}), 0);
        tick(); tick();
        RST_n = 1'b1;
        repeat (6) begin chk("post_rst_quiet", 32'({pm_we, busy}), 0); tick(); end

        gnt_rand = 1'b1;
        repeat (400) begin
            send(AW'(12'h050 + $urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), $urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        gnt_rand = 1'b0;
        tick();
        pm_gnt = 1'b1;
        drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
